// File: rtl/exu_pkg.sv
// Shared types and constants for the execute stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package exu_pkg;

  // Kind of instruction presented by decode to the execute stage
  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_BRANCH = 2'd1,
    OP_JAL    = 2'd2,
    OP_JALR   = 2'd3
  } op_kind_t;

  // Fixed instruction length in bytes (no compressed encodings)
  localparam int ILEN_BYTES = 4;

  // Width of the alu_type encoding
  localparam int ALU_ARGS_W = 5;

  // alu_type encodings; compare ops return 0/1 in bit 0, JALR returns (a+b) & ~1
  localparam logic [ALU_ARGS_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_ARGS_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_ARGS_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_ARGS_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_ARGS_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_ARGS_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [ALU_ARGS_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_ARGS_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_ARGS_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [ALU_ARGS_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [ALU_ARGS_W-1:0] ALU_BEQ  = 5'd10;
  localparam logic [ALU_ARGS_W-1:0] ALU_BNE  = 5'd11;
  localparam logic [ALU_ARGS_W-1:0] ALU_BLT  = 5'd12;
  localparam logic [ALU_ARGS_W-1:0] ALU_BGE  = 5'd13;
  localparam logic [ALU_ARGS_W-1:0] ALU_BLTU = 5'd14;
  localparam logic [ALU_ARGS_W-1:0] ALU_BGEU = 5'd15;
  localparam logic [ALU_ARGS_W-1:0] ALU_JALR = 5'd16;

endpackage

// File: rtl/exu_stage_alu.sv
// Integer ALU: arithmetic, logic, shifts, compares and JALR target generation.
// Latency: 0 (purely combinational).
// Backpressure: none; result follows inputs every cycle.
module exu_stage_alu
  import exu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ARGS_W = ALU_ARGS_W
) (
  input  logic [ARGS_W-1:0] alu_type,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0]    shamt;
  logic [DATA_W-1:0] sum;

  assign shamt = b[SHW-1:0];
  assign sum   = a + b;

  // Select the operation result; unknown encodings yield zero
  always_comb begin
    res = '0;
    case (alu_type)
      ALU_ADD:  res = sum;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = DATA_W'($signed(a) >>> shamt);
      ALU_SLT:  res = DATA_W'($signed(a) < $signed(b));
      ALU_SLTU: res = DATA_W'(a < b);
      ALU_BEQ:  res = DATA_W'(a == b);
      ALU_BNE:  res = DATA_W'(a != b);
      ALU_BLT:  res = DATA_W'($signed(a) < $signed(b));
      ALU_BGE:  res = DATA_W'($signed(a) >= $signed(b));
      ALU_BLTU: res = DATA_W'(a < b);
      ALU_BGEU: res = DATA_W'(a >= b);
      ALU_JALR: res = {sum[DATA_W-1:1], 1'b0};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: operand select, ALU, branch/jump resolve, EX/LS pipeline register.
// Latency: 1 cycle from ID accept to o_ex_* and the one-cycle redirect pulse.
// Backpressure: o_id_ready = !o_ex_valid | i_ex_ready; payload held while LS stalls.
module exu_stage
  import exu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ARGS_W = ALU_ARGS_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [ADDR_W-1:0] i_id_pc,
  input  op_kind_t          i_id_op_kind,
  input  logic [ARGS_W-1:0] i_id_alu_type,
  input  logic              i_id_src1_pc,
  input  logic              i_id_src2_imm,
  input  logic [DATA_W-1:0] i_id_rs1_data,
  input  logic [DATA_W-1:0] i_id_rs2_data,
  input  logic [DATA_W-1:0] i_id_imm,
  input  logic [4:0]        i_id_rd_addr,
  input  logic              i_id_rd_wen,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [ADDR_W-1:0] o_ex_pc,
  output logic [DATA_W-1:0] o_ex_res,
  output logic [DATA_W-1:0] o_ex_rs2_data,
  output logic [4:0]        o_ex_rd_addr,
  output logic              o_ex_rd_wen,
  output logic              o_ex_misalign,
  output logic              o_br_taken,
  output logic [ADDR_W-1:0] o_br_target
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] res_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt;
  logic              taken;
  logic              misalign;
  logic              rd_wen_d;
  logic              load;
  // Set with an accepted taken, aligned transfer; drives the single redirect pulse
  logic              br_pending;

  assign op_a = i_id_src1_pc  ? DATA_W'(i_id_pc) : i_id_rs1_data;
  assign op_b = i_id_src2_imm ? i_id_imm         : i_id_rs2_data;

  exu_stage_alu #(
    .DATA_W (DATA_W),
    .ARGS_W (ARGS_W)
  ) u_alu (
    .alu_type (i_id_alu_type),
    .a        (op_a),
    .b        (op_b),
    .res      (alu_res)
  );

  // Resolve control flow and pick the value written back for this instruction
  always_comb begin
    pc_inc = i_id_pc + ADDR_W'(ILEN_BYTES);
    tgt    = i_id_pc + i_id_imm[ADDR_W-1:0];
    taken  = 1'b0;
    res_d  = alu_res;
    case (i_id_op_kind)
      OP_BRANCH: taken = alu_res[0];
      OP_JAL: begin
        taken = 1'b1;
        res_d = DATA_W'(pc_inc);
      end
      OP_JALR: begin
        taken = 1'b1;
        tgt   = alu_res[ADDR_W-1:0];
        res_d = DATA_W'(pc_inc);
      end
      default: ;
    endcase
  end

  // A taken target off a 4-byte boundary raises an exception instead of redirecting
  assign misalign = taken & (tgt[1:0] != 2'b00);
  assign rd_wen_d = i_id_rd_wen & (i_id_rd_addr != 5'd0) & ~misalign;

  assign o_id_ready = ~o_ex_valid | i_ex_ready;
  // Handshakes during a flush or in the redirect cycle are wrong-path and dropped
  assign load       = i_id_valid & o_id_ready & ~i_flush & ~br_pending;
  assign o_br_taken = br_pending;

  // Occupancy of the EX/LS register and the redirect pulse tracker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_valid <= 1'b0;
      br_pending <= 1'b0;
    end else if (i_flush) begin
      o_ex_valid <= 1'b0;
      br_pending <= 1'b0;
    end else begin
      o_ex_valid <= load | (o_ex_valid & ~i_ex_ready);
      br_pending <= load & taken & ~misalign;
    end
  end

  // Payload and redirect target capture on accept; held otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_pc       <= '0;
      o_ex_res      <= '0;
      o_ex_rs2_data <= '0;
      o_ex_rd_addr  <= '0;
      o_ex_rd_wen   <= 1'b0;
      o_ex_misalign <= 1'b0;
      o_br_target   <= '0;
    end else if (load) begin
      o_ex_pc       <= i_id_pc;
      o_ex_res      <= res_d;
      o_ex_rs2_data <= i_id_rs2_data;
      o_ex_rd_addr  <= i_id_rd_addr;
      o_ex_rd_wen   <= rd_wen_d;
      o_ex_misalign <= misalign;
      o_br_target   <= tgt;
    end
  end

endmodule
